// File: rtl/audio_sample_cacher.sv
// ============================================================================
// audio_sample_cacher
// Buffers stereo sample pairs and writes them into the SRAM audio ring buffer.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module audio_sample_cacher #(
    parameter int         FIFO_DEPTH = 8,
    parameter logic [3:0] AUDIO_BANK = 4'hF
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic                          Enable,
    input  logic                          SampleValid,
    input  logic [15:0]                   SampleL,
    input  logic [15:0]                   SampleR,
    input  logic                          ClearOvf,
    input  logic                          AddrValid,
    output logic                          ReqWrite,
    output logic [17:0]                   WrAddress,
    output logic [15:0]                   WrData,
    output logic [12:0]                   LastWriteAddr,
    output logic                          Overflow,
    output logic [$clog2(FIFO_DEPTH):0]   FifoLevel
);

    localparam int             AW         = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]    FULL_COUNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]    CNT_ONE    = (AW+1)'(1);
    localparam logic [AW-1:0]  PTR_ONE    = AW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR_L = 2'd1,
        ST_WR_R = 2'd2
    } state_t;

    state_t        state;
    logic [31:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] fifo_wr;
    logic [AW-1:0] fifo_rd;
    logic [AW:0]   fifo_count;
    logic [12:0]   wptr;
    logic [15:0]   hold_r;

    logic          fifo_full;
    logic          fifo_nonempty;
    logic          push;
    logic          drop;
    logic          pop;
    logic [31:0]   fifo_head;

    assign fifo_full     = (fifo_count == FULL_COUNT);
    assign fifo_nonempty = (fifo_count != '0);
    assign push          = SampleValid & Enable & ~fifo_full;
    // A full FIFO drops the pair even if a pop frees a slot on the same edge.
    assign drop          = SampleValid & Enable & fifo_full;
    assign fifo_head     = fifo_mem[fifo_rd];
    assign FifoLevel     = fifo_count;

    always_comb begin
        pop = 1'b0;
        case (state)
            ST_IDLE: pop = fifo_nonempty;
            ST_WR_R: pop = AddrValid & fifo_nonempty;
            default: pop = 1'b0;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (push) begin
            fifo_mem[fifo_wr] <= {SampleL, SampleR};
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            fifo_wr    <= '0;
            fifo_rd    <= '0;
            fifo_count <= '0;
        end else begin
            if (push) fifo_wr <= fifo_wr + PTR_ONE;
            if (pop)  fifo_rd <= fifo_rd + PTR_ONE;
            if (push && !pop)      fifo_count <= fifo_count + CNT_ONE;
            else if (!push && pop) fifo_count <= fifo_count - CNT_ONE;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Overflow <= 1'b0;
        end else if (drop) begin
            Overflow <= 1'b1;
        end else if (ClearOvf) begin
            Overflow <= 1'b0;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state         <= ST_IDLE;
            wptr          <= '0;
            hold_r        <= '0;
            ReqWrite      <= 1'b0;
            WrAddress     <= '0;
            WrData        <= '0;
            LastWriteAddr <= 13'h1FFF;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fifo_nonempty) begin
                        hold_r    <= fifo_head[15:0];
                        ReqWrite  <= 1'b1;
                        WrAddress <= {AUDIO_BANK, 1'b0, wptr};
                        WrData    <= fifo_head[31:16];
                        state     <= ST_WR_L;
                    end
                end
                ST_WR_L: begin
                    if (AddrValid) begin
                        WrAddress <= {AUDIO_BANK, 1'b1, wptr};
                        WrData    <= hold_r;
                        state     <= ST_WR_R;
                    end
                end
                ST_WR_R: begin
                    if (AddrValid) begin
                        // Publish only once the R word is in SRAM.
                        LastWriteAddr <= wptr;
                        wptr          <= wptr + 13'd1;
                        if (fifo_nonempty) begin
                            hold_r    <= fifo_head[15:0];
                            WrAddress <= {AUDIO_BANK, 1'b0, wptr + 13'd1};
                            WrData    <= fifo_head[31:16];
                            state     <= ST_WR_L;
                        end else begin
                            ReqWrite  <= 1'b0;
                            state     <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    ReqWrite <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
